vector_playback_ctrl: RTL and testbench

Read-side sequencer for the PC-to-vector FIFO (32-bit, standard-read, 1-cycle read latency) in the vectorclk domain. Replaces the free-running read with a controlled playback. Start/stop control, programmable dwell per vector (hold_cycles), finite or continuous vector count. Drives the registered vectoroutput bus and reports underflow and progress to the host status registers.

---
 rtl/vector_playback_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vector_playback_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_playback_ctrl.sv
// Purpose : read-side playback sequencer for the PC-to-vector FIFO; applies one FIFO word per dwell period.
// Latency : start in cycle 0 -> fifo_rd_en in cycle 1 -> vectoroutput updated at the end of cycle 2.
// Backpr. : never reads an empty FIFO; a dry FIFO mid-run parks in FETCH with sticky underflow and vectoroutput held.
//
// Ports:
//   vectorclk, vectorreset_n    sole clock, async active-low reset
//   start, stop                 1-cycle control pulses (stop has priority)
//   hold_cycles, vector_count   run configuration, latched on start (count 0 = continuous)
//   fifo_dout, fifo_empty       FIFO read data (1-cycle latency) and empty flag
//   fifo_rd_en                  FIFO read strobe (combinational)
//   vectoroutput                applied vector (registered)
//   busy, done, underflow       status: running, finite-run completion pulse, sticky underflow
//   vectors_played              vectors applied since the last start
module vector_playback_ctrl #(
    parameter int               WIDTH       = 32,
    parameter int               DIV_W       = 16,
    parameter int               CNT_W       = 32,
    parameter logic [WIDTH-1:0] IDLE_VECTOR = '0
) (
    input  logic             vectorclk,
    input  logic             vectorreset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0] vector_count,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] vectoroutput,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [CNT_W-1:0] vectors_played
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             pend;          // read issued last cycle, fifo_dout valid now
    logic [DIV_W-1:0] dwell;         // idle cycles left after the load cycle
    logic [DIV_W-1:0] hold_shadow;
    logic [CNT_W-1:0] count_shadow;

    logic             load;
    logic             final_cyc;
    logic             is_last;
    logic             launch;
    logic             done_set;
    logic             underflow_set;
    logic [CNT_W-1:0] played_inc;
    logic [CNT_W-1:0] played_cur;

    assign busy = (state != ST_IDLE);

    always_comb begin
        launch = (state == ST_IDLE) && start && !stop;

        // Data from a read issued just before a stop is swallowed.
        load = pend && !stop && (state != ST_IDLE);

        // Saturating increment keeps continuous runs from wrapping.
        played_inc = (vectors_played == {CNT_W{1'b1}}) ? vectors_played
                                                       : vectors_played + CNT_W'(1);
        played_cur = load ? played_inc : vectors_played;

        is_last = (count_shadow != '0) && (played_cur == count_shadow);

        // The load cycle is itself the first cycle of the dwell period, so with
        // hold 0 it is also the final one; otherwise the counter runs down to 0.
        final_cyc = (state == ST_PLAY) &&
                    (pend ? (hold_shadow == '0) : (dwell == '0));

        fifo_rd_en = 1'b0;
        unique case (state)
            ST_FETCH: fifo_rd_en = !fifo_empty && !stop;
            ST_PLAY:  fifo_rd_en = final_cyc && !is_last && !fifo_empty && !stop;
            default:  fifo_rd_en = 1'b0;
        endcase

        done_set      = !stop && final_cyc && is_last;
        underflow_set = !stop && final_cyc && !is_last && fifo_empty;

        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (!fifo_empty) state_nxt = ST_PLAY;
                end
                ST_PLAY: begin
                    if (final_cyc) begin
                        if (is_last)          state_nxt = ST_IDLE;
                        else if (!fifo_empty) state_nxt = ST_PLAY;
                        else                  state_nxt = ST_FETCH;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= fifo_rd_en;
            done  <= done_set;
        end
    end

    // Run configuration is frozen for the whole run.
    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            hold_shadow  <= '0;
            count_shadow <= '0;
        end else if (launch) begin
            hold_shadow  <= hold_cycles;
            count_shadow <= vector_count;
        end
    end

    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            vectoroutput <= IDLE_VECTOR;
        end else if (load) begin
            vectoroutput <= fifo_dout;
        end
    end

    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            vectors_played <= '0;
        end else if (launch) begin
            vectors_played <= '0;
        end else if (load) begin
            vectors_played <= played_inc;
        end
    end

    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            dwell <= '0;
        end else if (load) begin
            dwell <= (hold_shadow == '0) ? '0 : hold_shadow - DIV_W'(1);
        end else if ((state == ST_PLAY) && !pend && (dwell != '0)) begin
            dwell <= dwell - DIV_W'(1);
        end
    end

    always_ff @(posedge vectorclk or negedge vectorreset_n) begin
        if (!vectorreset_n) begin
            underflow <= 1'b0;
        end else if (launch) begin
            underflow <= 1'b0;
        end else if (underflow_set) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_playback_ctrl.sv
// Purpose : directed self-checking bench for vector_playback_ctrl with a behavioural 1-cycle-latency FIFO.
// Latency : inputs are driven just after each falling edge and outputs sampled 1 time unit later.
// Backpr. : the FIFO model counts any read strobe seen while it is empty.
module tb_vector_playback_ctrl;

    localparam int WIDTH = 32;
    localparam int DIV_W = 16;
    localparam int CNT_W = 32;

    logic             vectorclk     = 1'b0;
    logic             vectorreset_n = 1'b0;
    logic             start         = 1'b0;
    logic             stop          = 1'b0;
    logic [DIV_W-1:0] hold_cycles   = '0;
    logic [CNT_W-1:0] vector_count  = '0;
    logic [WIDTH-1:0] fifo_dout     = '0;
    logic             fifo_empty    = 1'b1;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] vectoroutput;
    logic             busy;
    logic             done;
    logic             underflow;
    logic [CNT_W-1:0] vectors_played;

    int n_cmp  = 0;
    int n_fail = 0;

    logic             push_vld = 1'b0;
    logic [WIDTH-1:0] push_dat = '0;
    logic             flush    = 1'b0;
    logic [WIDTH-1:0] fq[$];
    int               rd_on_empty = 0;

    vector_playback_ctrl #(
        .WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W), .IDLE_VECTOR(32'h0)
    ) dut (
        .vectorclk      (vectorclk),
        .vectorreset_n  (vectorreset_n),
        .start          (start),
        .stop           (stop),
        .hold_cycles    (hold_cycles),
        .vector_count   (vector_count),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .vectoroutput   (vectoroutput),
        .busy           (busy),
        .done           (done),
        .underflow      (underflow),
        .vectors_played (vectors_played)
    );

    always #5 vectorclk = ~vectorclk;

    // Standard-read FIFO: data appears on fifo_dout the cycle after the strobe;
    // a write clears the empty flag from the next cycle on.
    always @(posedge vectorclk) begin
        if (flush) begin
            fq.delete();
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() != 0) fifo_dout <= fq.pop_front();
                else                rd_on_empty++;
            end
            if (push_vld) fq.push_back(push_dat);
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic preload(input logic [WIDTH-1:0] d);
        @(negedge vectorclk);
        push_vld = 1'b1;
        push_dat = d;
        @(negedge vectorclk);
        push_vld = 1'b0;
    endtask

    task automatic fifo_flush();
        @(negedge vectorclk);
        flush = 1'b1;
        @(negedge vectorclk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (vectoroutput !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 00000000", vectoroutput); end
        n_cmp++; if ({fifo_rd_en, busy, done, underflow} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {fifo_rd_en, busy, done, underflow}); end
        n_cmp++; if (vectors_played !== '0) begin n_fail++; $display("FAIL reset_played: got %0d want 0", vectors_played); end
        @(negedge vectorclk);
        vectorreset_n = 1'b1;
    endtask

    // hold 0, count 4: four back-to-back reads, one vector per cycle.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] eo [0:7];
        logic [7:0] erd, edn, ebz;
        int ndone;
        eo  = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
        erd = 8'h1E; edn = 8'h40; ebz = 8'h3E;
        ndone = 0;
        hold_cycles = 16'd0; vector_count = 32'd4;
        for (int k = 1; k <= 4; k++) preload(32'(k));
        for (int i = 0; i < 8; i++) begin
            @(negedge vectorclk);
            start = (i == 0);
            #1;
            if (done === 1'b1) ndone++;
            n_cmp++; if (fifo_rd_en !== erd[i]) begin n_fail++; $display("FAIL b2b_rd c%0d: got %b want %b", i, fifo_rd_en, erd[i]); end
            n_cmp++; if (vectoroutput !== eo[i]) begin n_fail++; $display("FAIL b2b_out c%0d: got %h want %h", i, vectoroutput, eo[i]); end
            n_cmp++; if (done !== edn[i]) begin n_fail++; $display("FAIL b2b_done c%0d: got %b want %b", i, done, edn[i]); end
            n_cmp++; if (busy !== ebz[i]) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b want %b", i, busy, ebz[i]); end
        end
        n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
        n_cmp++; if (vectors_played !== 32'd4) begin n_fail++; $display("FAIL b2b_played: got %0d want 4", vectors_played); end
    endtask

    // hold 2, count 3: each word applied for exactly 3 cycles.
    task automatic test_dwell();
        logic [WIDTH-1:0] eo [0:12];
        logic [12:0] erd, edn, ebz;
        logic [WIDTH-1:0] a, b, c;
        a = 32'hA0A0_0001; b = 32'hB0B0_0002; c = 32'hC0C0_0003;
        eo  = '{32'd4, 32'd4, 32'd4, a, a, a, b, b, b, c, c, c, c};
        erd = 13'h0092; edn = 13'h0800; ebz = 13'h07FE;
        hold_cycles = 16'd2; vector_count = 32'd3;
        preload(a); preload(b); preload(c);
        for (int i = 0; i < 13; i++) begin
            @(negedge vectorclk);
            start = (i == 0);
            #1;
            n_cmp++; if (fifo_rd_en !== erd[i]) begin n_fail++; $display("FAIL dwell_rd c%0d: got %b want %b", i, fifo_rd_en, erd[i]); end
            n_cmp++; if (vectoroutput !== eo[i]) begin n_fail++; $display("FAIL dwell_out c%0d: got %h want %h", i, vectoroutput, eo[i]); end
            n_cmp++; if (done !== edn[i]) begin n_fail++; $display("FAIL dwell_done c%0d: got %b want %b", i, done, edn[i]); end
            n_cmp++; if (busy !== ebz[i]) begin n_fail++; $display("FAIL dwell_busy c%0d: got %b want %b", i, busy, ebz[i]); end
        end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL dwell_underflow: got %b want 0", underflow); end
        n_cmp++; if (vectors_played !== 32'd3) begin n_fail++; $display("FAIL dwell_played: got %0d want 3", vectors_played); end
    endtask

    // Continuous mode: FIFO runs dry after 2 words, then one more word resumes playback.
    task automatic test_underflow();
        logic [WIDTH-1:0] eo [0:12];
        logic [12:0] erd, ebz, euf;
        logic [WIDTH-1:0] w1, w2, w3, c;
        w1 = 32'h1111_0001; w2 = 32'h2222_0002; w3 = 32'h3333_0003; c = 32'hC0C0_0003;
        eo  = '{c, c, c, w1, w2, w2, w2, w2, w2, w2, w3, w3, w3};
        erd = 13'h0106; ebz = 13'h0FFE; euf = 13'h1FF0;
        hold_cycles = 16'd0; vector_count = 32'd0;
        preload(w1); preload(w2);
        for (int i = 0; i < 13; i++) begin
            @(negedge vectorclk);
            start    = (i == 0);
            push_vld = (i == 7);
            push_dat = w3;
            stop     = (i == 11);
            #1;
            n_cmp++; if (fifo_rd_en !== erd[i]) begin n_fail++; $display("FAIL uf_rd c%0d: got %b want %b", i, fifo_rd_en, erd[i]); end
            n_cmp++; if (vectoroutput !== eo[i]) begin n_fail++; $display("FAIL uf_out c%0d: got %h want %h", i, vectoroutput, eo[i]); end
            n_cmp++; if (busy !== ebz[i]) begin n_fail++; $display("FAIL uf_busy c%0d: got %b want %b", i, busy, ebz[i]); end
            n_cmp++; if (underflow !== euf[i]) begin n_fail++; $display("FAIL uf_flag c%0d: got %b want %b", i, underflow, euf[i]); end
            if (i == 4) begin
                n_cmp++; if (vectors_played !== 32'd2) begin n_fail++; $display("FAIL uf_played2: got %0d want 2", vectors_played); end
            end
            if (i == 10) begin
                n_cmp++; if (vectors_played !== 32'd3) begin n_fail++; $display("FAIL uf_played3: got %0d want 3", vectors_played); end
            end
        end
        stop = 1'b0; push_vld = 1'b0;
    endtask

    // hold 5: stop in the middle of the dwell; nothing else happens afterwards.
    task automatic test_stop();
        logic [WIDTH-1:0] x, w3;
        logic [9:0] erd, ebz;
        x = 32'h5A5A_0001; w3 = 32'h3333_0003;
        erd = 10'h002; ebz = 10'h01E;
        hold_cycles = 16'd5; vector_count = 32'd0;
        preload(x); preload(32'h5A5A_0002); preload(32'h5A5A_0003);
        for (int i = 0; i < 10; i++) begin
            @(negedge vectorclk);
            start = (i == 0);
            stop  = (i == 4);
            #1;
            n_cmp++; if (fifo_rd_en !== erd[i]) begin n_fail++; $display("FAIL stop_rd c%0d: got %b want %b", i, fifo_rd_en, erd[i]); end
            n_cmp++; if (busy !== ebz[i]) begin n_fail++; $display("FAIL stop_busy c%0d: got %b want %b", i, busy, ebz[i]); end
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done c%0d: got %b want 0", i, done); end
            n_cmp++; if (vectoroutput !== ((i < 3) ? w3 : x)) begin n_fail++; $display("FAIL stop_out c%0d: got %h want %h", i, vectoroutput, (i < 3) ? w3 : x); end
        end
        stop = 1'b0;
        n_cmp++; if (vectors_played !== 32'd1) begin n_fail++; $display("FAIL stop_played: got %0d want 1", vectors_played); end
        fifo_flush();
    endtask

    // Reset dropped between clock edges while playing with underflow set.
    task automatic test_async_reset();
        logic [WIDTH-1:0] p1, p2;
        p1 = 32'hFEED_0001; p2 = 32'hFEED_0002;
        hold_cycles = 16'd3; vector_count = 32'd0;
        preload(p1);
        for (int i = 0; i < 10; i++) begin
            @(negedge vectorclk);
            start    = (i == 0);
            push_vld = (i == 6);
            push_dat = p2;
        end
        push_vld = 1'b0;
        #1;
        n_cmp++; if ({busy, underflow, vectoroutput} !== {1'b1, 1'b1, p2}) begin n_fail++; $display("FAIL arst_pre: got busy=%b uf=%b out=%h want busy=1 uf=1 out=%h", busy, underflow, vectoroutput, p2); end
        n_cmp++; if (vectors_played !== 32'd2) begin n_fail++; $display("FAIL arst_pre_played: got %0d want 2", vectors_played); end
        #1;
        vectorreset_n = 1'b0;
        #1;
        n_cmp++; if (vectoroutput !== 32'h0) begin n_fail++; $display("FAIL arst_out: got %h want 00000000", vectoroutput); end
        n_cmp++; if ({fifo_rd_en, busy, done, underflow} !== 4'b0000) begin n_fail++; $display("FAIL arst_flags: got %b want 0000", {fifo_rd_en, busy, done, underflow}); end
        n_cmp++; if (vectors_played !== '0) begin n_fail++; $display("FAIL arst_played: got %0d want 0", vectors_played); end
        @(negedge vectorclk);
        vectorreset_n = 1'b1;
        fifo_flush();
    endtask

    // start+stop together is a no-op; a second start mid-run is ignored.
    task automatic test_start_collisions();
        hold_cycles = 16'd4; vector_count = 32'd0;
        preload(32'h0BAD_0001);
        @(negedge vectorclk);
        start = 1'b1; stop = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge vectorclk);
            start = 1'b0; stop = 1'b0;
            #1;
            n_cmp++; if ({busy, fifo_rd_en} !== 2'b00) begin n_fail++; $display("FAIL startstop c%0d: got busy,rd=%b want 00", i, {busy, fifo_rd_en}); end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge vectorclk);
            start = (i == 0) || (i == 3);
            hold_cycles = (i == 3) ? 16'd0 : 16'd4;
            #1;
            if (i >= 4) begin
                n_cmp++; if (vectors_played !== 32'd1) begin n_fail++; $display("FAIL restart_played c%0d: got %0d want 1", i, vectors_played); end
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy c%0d: got %b want 1", i, busy); end
            end
        end
        start = 1'b0;
        n_cmp++; if (vectoroutput !== 32'h0BAD_0001) begin n_fail++; $display("FAIL restart_out: got %h want 0bad0001", vectoroutput); end
        @(negedge vectorclk);
        stop = 1'b1;
        @(negedge vectorclk);
        stop = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_stop_busy: got %b want 0", busy); end
        n_cmp++; if (rd_on_empty != 0) begin n_fail++; $display("FAIL read_when_empty: got %0d want 0", rd_on_empty); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_dwell();
        test_underflow();
        test_stop();
        test_async_reset();
        test_start_collisions();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
